sha256_sched_ctrl: RTL and testbench
====================================

# sha256_sched_ctrl

Message-schedule sequencer for the SHA-256 core. It accepts one 512-bit block as sixteen 32-bit words through a valid/ready handshake and holds them in a 16-word sliding window. It then streams W[0]..W[ROUNDS-1] to the compression round logic, one word per accepted transfer, computing each extension word in a single cycle. It sits between the block padder (upstream) and the compression FSM (downstream), and owns the shift enables and round counting for the window.

## Interface
- n, 32: word width; the algorithm fixes it at 32 (elaboration error otherwise)
- m, 16: window depth in words; fixed at 16
- ROUNDS, 64: words emitted per block; legal range 16..64
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- blk_valid_i  in  1  upstream block valid
- blk_ready_o  out  1  block accept
- m_i  in  n x [0:m-1]  block words; m_i[0] is W[0]
- w_valid_o  out  1  schedule word valid
- w_ready_i  in  1  downstream accepts word
- w_o  out  n  current schedule word W[t]
- t_o  out  6  current round index t
- last_o  out  1  high with w_valid_o when t_o == ROUNDS-1
- busy_o  out  1  high in RUN
- abort_i  in  1  synchronous abort, highest priority

## Operation
- States: IDLE, RUN.
- Reset (rst_i low, asynchronous):
  - state goes to IDLE; window win[0..15] = 0; t = 0.
  - Output values during and immediately after reset: w_valid_o=0, w_o=0, t_o=0, last_o=0, busy_o=0, blk_ready_o=1.
- IDLE:
  - blk_ready_o = ~abort_i.
  - On blk_valid_i & blk_ready_o: win[i] <= m_i[i] for all i; t <= 0; go to RUN.
- RUN:
  - w_valid_o = 1; w_o = win[0]; t_o = t; busy_o = 1; blk_ready_o = 0.
  - On w_valid_o & w_ready_i & ~abort_i:
    - win[i] <= win[i+1] for i = 0..14.
    - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^32.
    - t <= t+1.
    - If t == ROUNDS-1: go to IDLE instead, and t <= 0.
- sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
- sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Extension is computed on every shift, including rounds 0..15, so win[0] always equals W[t]. No carry out and no overflow flag.
- abort_i:
  - In RUN: go to IDLE on the next edge and set t <= 0. The window keeps its contents; the value is don't-care.
  - If abort_i coincides with a downstream handshake, the word counts as consumed by the sink, but no shift happens.
  - In IDLE: blocks acceptance that cycle.
- w_ready_i low in RUN stalls the block: the window, t, w_o, t_o and last_o all hold. w_valid_o never drops without a handshake, except on abort or reset.
- blk_valid_i and m_i are ignored outside IDLE.

## Timing
- Block accepted at edge E: W[0] is valid on w_o after E, in the next cycle.
- With w_ready_i held high: W[t] is presented in cycle E+1+t.
  - last_o is high in cycle E+ROUNDS.
  - blk_ready_o returns high in cycle E+ROUNDS+1.
- Minimum block period is ROUNDS+1 cycles. There is no overlap of a new load with the tail of a block.
- Combinational paths:
  - w_o, t_o and last_o come from registers only.
  - The extension adder is a single-cycle path: four 32-bit operands.
  - blk_ready_o depends combinationally on abort_i only.
- Reset mid-run: all outputs take their reset values immediately. A partially streamed block is lost; the upstream must re-present it.

## Test plan
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready_i=1 -> stream:
  - W0..W15 equal the inputs;
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405;
  - exactly 64 words, last_o only with t_o=63;
  - blk_ready_o high 65 cycles after acceptance.
- All-zero block -> 64 words all 0x00000000, t_o incrementing 0..63.
- Same "abc" block with w_ready_i toggled pseudo-randomly (50%) -> identical word sequence to the unstalled run; w_o and t_o stable while w_ready_i=0.
- Two blocks offered back-to-back with blk_valid_i held high -> second block accepted only in the cycle blk_ready_o rises; its W0 follows immediately, with no mixing of window contents.
- abort_i pulsed at t_o=20 together with w_ready_i=1 -> IDLE next cycle, w_valid_o=0, t_o=0. A fresh block then yields a correct W0..W63.
- rst_i driven low mid-stream at t_o=40 -> outputs go to their reset values without waiting for a clock edge. After release, blk_ready_o=1 and the next block streams correctly.

Source files
------------

// File: rtl/sha256_sched_ctrl.sv
// rtl/sha256_sched_ctrl.sv - SHA-256 message-schedule sequencer with a 16-word sliding window
//
// Purpose: loads one 512-bit block as sixteen 32-bit words, then streams
// W[0]..W[ROUNDS-1] downstream, extending the window by one word per accepted
// transfer.
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_i        asynchronous active-low reset
//   blk_valid_i  upstream block valid
//   blk_ready_o  block accept (IDLE and no abort)
//   m_i          block words, m_i[0] is W[0]
//   w_valid_o    schedule word valid (high throughout RUN)
//   w_ready_i    downstream accepts word
//   w_o          current schedule word W[t]
//   t_o          current round index t
//   last_o       high with w_valid_o on the final round
//   busy_o       high in RUN
//   abort_i      synchronous abort, highest priority

module sha256_sched_ctrl #(
  parameter int n      = 32,
  parameter int m      = 16,
  parameter int ROUNDS = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                blk_valid_i,
  output logic                blk_ready_o,
  input  logic [0:m-1][n-1:0] m_i,
  output logic                w_valid_o,
  input  logic                w_ready_i,
  output logic [n-1:0]        w_o,
  output logic [5:0]          t_o,
  output logic                last_o,
  output logic                busy_o,
  input  logic                abort_i
);

  if (n != 32) begin : g_bad_n
    $error("sha256_sched_ctrl: n must be 32");
  end
  if (m != 16) begin : g_bad_m
    $error("sha256_sched_ctrl: m must be 16");
  end
  if (ROUNDS < 16 || ROUNDS > 64) begin : g_bad_rounds
    $error("sha256_sched_ctrl: ROUNDS must be in 16..64");
  end

  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [n-1:0] win_q [0:m-1];
  logic [5:0]   t_q;
  logic         load_en;
  logic         shift_en;
  logic [n-1:0] ext_w;

  function automatic logic [n-1:0] sig0(input logic [n-1:0] x);
    return {x[6:0], x[n-1:7]} ^ {x[17:0], x[n-1:18]} ^ (x >> 3);
  endfunction

  function automatic logic [n-1:0] sig1(input logic [n-1:0] x);
    return {x[16:0], x[n-1:17]} ^ {x[18:0], x[n-1:19]} ^ (x >> 10);
  endfunction

  // Extension runs on every shift, even while the loaded words are still
  // draining, so win_q[0] is always W[t] without a separate load/extend mux.
  assign ext_w = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      t_q     <= '0;
      for (int i = 0; i < m; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (load_en) begin
        for (int i = 0; i < m; i++) begin
          win_q[i] <= m_i[i];
        end
        t_q <= '0;
      end else if (shift_en) begin
        for (int i = 0; i < m - 1; i++) begin
          win_q[i] <= win_q[i+1];
        end
        win_q[m-1] <= ext_w;
        t_q        <= (t_q == T_LAST) ? 6'd0 : t_q + 6'd1;
      end else if (state_q == RUN && abort_i) begin
        // Window contents are left as-is; only the round counter matters.
        t_q <= '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    blk_ready_o = 1'b0;
    w_valid_o   = 1'b0;
    busy_o      = 1'b0;
    load_en     = 1'b0;
    shift_en    = 1'b0;
    w_o         = '0;
    t_o         = t_q;
    last_o      = 1'b0;
    case (state_q)
      IDLE: begin
        blk_ready_o = ~abort_i;
        if (blk_valid_i && !abort_i) begin
          load_en = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        w_valid_o = 1'b1;
        busy_o    = 1'b1;
        w_o       = win_q[0];
        last_o    = (t_q == T_LAST);
        if (abort_i) begin
          // A coincident handshake still counts as consumed downstream.
          state_d = IDLE;
        end else if (w_ready_i) begin
          shift_en = 1'b1;
          if (t_q == T_LAST) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// tb/tb_sha256_sched_ctrl.sv - scoreboard bench for sha256_sched_ctrl

module tb_sha256_sched_ctrl;

  localparam int ROUNDS = 64;

  logic              clk_i;
  logic              rst_i;
  logic              blk_valid_i;
  logic              blk_ready_o;
  logic [0:15][31:0] m_i;
  logic              w_valid_o;
  logic              w_ready_i;
  logic [31:0]       w_o;
  logic [5:0]        t_o;
  logic              last_o;
  logic              busy_o;
  logic              abort_i;

  sha256_sched_ctrl #(.n(32), .m(16), .ROUNDS(ROUNDS)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .blk_valid_i (blk_valid_i),
    .blk_ready_o (blk_ready_o),
    .m_i         (m_i),
    .w_valid_o   (w_valid_o),
    .w_ready_i   (w_ready_i),
    .w_o         (w_o),
    .t_o         (t_o),
    .last_o      (last_o),
    .busy_o      (busy_o),
    .abort_i     (abort_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  t;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] blk [16];
  logic [31:0] cap [64];
  int          n_cmp;
  int          n_err;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_expected();
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++) w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
    for (int i = 0; i < ROUNDS; i++) begin
      e.w = w[i];
      e.t = 6'(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_m();
    for (int i = 0; i < 16; i++) m_i[i] = blk[i];
  endtask

  task automatic offer_block(input bit hold, output int waited);
    set_m();
    blk_valid_i = 1'b1;
    waited = 0;
    @(negedge clk_i);
    while (!blk_ready_o && waited < 300) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      waited++;
    end
    n_cmp++;
    if (blk_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL offer_timeout: blk_ready_o=%b required 1", blk_ready_o);
    end
    push_expected();
    @(posedge clk_i); #1;
    if (!hold) blk_valid_i = 1'b0;
  endtask

  task automatic stream(input bit stall, input int max_words, output int cycles);
    exp_t e;
    int popped;
    popped = 0;
    cycles = 0;
    while (exp_q.size() > 0 && (max_words == 0 || popped < max_words) && cycles < 3000) begin
      w_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk_i);
      cycles++;
      e = exp_q[0];
      n_cmp++;
      if (w_valid_o !== 1'b1 || blk_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        n_err++;
        $display("FAIL run_flags t=%0d: w_valid=%b blk_ready=%b busy=%b required 1/0/1",
                 e.t, w_valid_o, blk_ready_o, busy_o);
      end
      n_cmp++;
      if (w_o !== e.w) begin
        n_err++;
        $display("FAIL word t=%0d: got %h required %h", e.t, w_o, e.w);
      end
      n_cmp++;
      if (t_o !== e.t) begin
        n_err++;
        $display("FAIL t_index: got %0d required %0d", t_o, e.t);
      end
      n_cmp++;
      if (last_o !== (e.t == 6'(ROUNDS - 1))) begin
        n_err++;
        $display("FAIL last t=%0d: got %b required %b", e.t, last_o, (e.t == 6'(ROUNDS - 1)));
      end
      if (w_ready_i) begin
        cap[e.t] = w_o;
        void'(exp_q.pop_front());
        popped++;
      end
      @(posedge clk_i); #1;
    end
    w_ready_i = 1'b0;
    n_cmp++;
    if (cycles >= 3000) begin
      n_err++;
      $display("FAIL stream_timeout: cycles=%0d required <3000", cycles);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk_i);
    n_cmp++;
    if (blk_ready_o !== 1'b1 || w_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        t_o !== 6'd0 || last_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_%s: ready=%b valid=%b busy=%b t=%0d last=%b required 1/0/0/0/0",
               tag, blk_ready_o, w_valid_o, busy_o, t_o, last_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    n_cmp++;
    if (w_valid_o !== 1'b0 || w_o !== 32'h0 || t_o !== 6'd0 || last_o !== 1'b0 ||
        busy_o !== 1'b0 || blk_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_%s: valid=%b w=%h t=%0d last=%b busy=%b ready=%b required 0/0/0/0/0/1",
               tag, w_valid_o, w_o, t_o, last_o, busy_o, blk_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    #12;
    check_reset_vals("during");
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_vals("after");
    @(posedge clk_i); #1;
  endtask

  task automatic test_abc();
    int wt, cyc;
    set_abc();
    offer_block(1'b0, wt);
    stream(1'b0, 0, cyc);
    n_cmp++;
    if (cyc !== ROUNDS) begin
      n_err++;
      $display("FAIL abc_cycles: got %0d required %0d", cyc, ROUNDS);
    end
    n_cmp++;
    if (cap[16] !== 32'h61626380 || cap[17] !== 32'h000F0000 || cap[18] !== 32'h7DA86405) begin
      n_err++;
      $display("FAIL abc_w16_18: got %h %h %h required 61626380 000f0000 7da86405",
               cap[16], cap[17], cap[18]);
    end
    check_idle("abc");
  endtask

  task automatic test_zero();
    int wt, cyc;
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    offer_block(1'b0, wt);
    stream(1'b0, 0, cyc);
    n_cmp++;
    if (cyc !== ROUNDS) begin
      n_err++;
      $display("FAIL zero_cycles: got %0d required %0d", cyc, ROUNDS);
    end
    check_idle("zero");
  endtask

  task automatic test_stall();
    int wt, cyc;
    set_abc();
    offer_block(1'b0, wt);
    stream(1'b1, 0, cyc);
    check_idle("stall");
  endtask

  task automatic test_back_to_back();
    int wt, cyc;
    set_abc();
    offer_block(1'b1, wt);
    for (int i = 0; i < 16; i++) blk[i] = $urandom();
    set_m();
    stream(1'b0, 0, cyc);
    n_cmp++;
    if (cyc !== ROUNDS) begin
      n_err++;
      $display("FAIL b2b_first_cycles: got %0d required %0d", cyc, ROUNDS);
    end
    offer_block(1'b1, wt);
    blk_valid_i = 1'b0;
    n_cmp++;
    if (wt !== 0) begin
      n_err++;
      $display("FAIL b2b_accept_wait: got %0d required 0", wt);
    end
    stream(1'b0, 0, cyc);
    n_cmp++;
    if (cyc !== ROUNDS) begin
      n_err++;
      $display("FAIL b2b_second_cycles: got %0d required %0d", cyc, ROUNDS);
    end
    check_idle("b2b");
  endtask

  task automatic test_abort();
    int wt, cyc;
    for (int i = 0; i < 16; i++) blk[i] = $urandom();
    offer_block(1'b0, wt);
    stream(1'b0, 20, cyc);
    w_ready_i = 1'b1;
    abort_i   = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (t_o !== 6'd20 || w_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL abort_pre: t=%0d valid=%b required 20/1", t_o, w_valid_o);
    end
    @(posedge clk_i); #1;
    abort_i   = 1'b0;
    w_ready_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    n_cmp++;
    if (w_valid_o !== 1'b0 || t_o !== 6'd0 || busy_o !== 1'b0 || blk_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL abort_post: valid=%b t=%0d busy=%b ready=%b required 0/0/0/1",
               w_valid_o, t_o, busy_o, blk_ready_o);
    end
    @(posedge clk_i); #1;
    set_abc();
    set_m();
    abort_i     = 1'b1;
    blk_valid_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (blk_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle_ready: got %b required 0", blk_ready_o);
    end
    @(posedge clk_i); #1;
    abort_i     = 1'b0;
    blk_valid_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (w_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle_accept: w_valid=%b required 0", w_valid_o);
    end
    @(posedge clk_i); #1;
    for (int i = 0; i < 16; i++) blk[i] = $urandom();
    offer_block(1'b0, wt);
    stream(1'b0, 0, cyc);
    check_idle("abort");
  endtask

  task automatic test_reset_midrun();
    int wt, cyc;
    set_abc();
    offer_block(1'b0, wt);
    stream(1'b0, 40, cyc);
    #1;
    rst_i = 1'b0;
    #1;
    check_reset_vals("midrun");
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_vals("midrun_release");
    @(posedge clk_i); #1;
    for (int i = 0; i < 16; i++) blk[i] = $urandom();
    offer_block(1'b0, wt);
    stream(1'b0, 0, cyc);
    check_idle("post_reset");
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_i       = 1'b0;
    blk_valid_i = 1'b0;
    w_ready_i   = 1'b0;
    abort_i     = 1'b0;
    m_i         = '0;
    for (int i = 0; i < 64; i++) cap[i] = 32'h0;
    test_reset();
    test_abc();
    test_zero();
    test_stall();
    test_back_to_back();
    test_abort();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
